// File: rtl/studio2_pkg.sv
// Shared types and constants for the Studio II keypad responder.
// Scan-code tables map PS/2 set-2 codes to keypad digits 0..9.
package studio2_pkg;

  localparam logic [2:0] DEFAULT_KEY_PORT = 3'd2;
  localparam int NUM_DIGITS = 10;

  typedef struct packed {
    logic       valid;
    logic       pad;    // 0 = keypad 1, 1 = keypad 2
    logic [3:0] digit;
  } key_evt_t;

  localparam logic [7:0] PAD1_CODES [NUM_DIGITS] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  localparam logic [7:0] PAD2_CODES [NUM_DIGITS] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

endpackage

// File: rtl/studio2_keypad_if.sv
// CPU-side bus of the keypad responder: OUT strobe/N/data in, EF flags out.
// io_out is a single-cycle strobe with no back-pressure; io_n and io_dout are
// only meaningful while io_out is high. ef and key_sel are always valid.
interface studio2_keypad_if;
  logic       io_out;
  logic [2:0] io_n;
  logic [7:0] io_dout;
  logic       efx;
  logic [3:0] ef;
  logic [3:0] key_sel;

  modport master (output io_out, io_n, io_dout, efx, input ef, key_sel);
  modport slave  (input io_out, io_n, io_dout, efx, output ef, key_sel);
endinterface

// File: rtl/studio2_keymap.sv
// Combinational decode of a PS/2 scan code into a keypad digit event.
// Extended codes never match, so numeric-keypad lookalikes with E0 are dropped.
import studio2_pkg::*;

module studio2_keymap (
  input  logic [7:0] code,
  input  logic       extended,
  output key_evt_t   evt
);

  always_comb begin
    evt = '0;
    if (!extended) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (code == PAD1_CODES[d]) begin
          evt.valid = 1'b1;
          evt.pad   = 1'b0;
          evt.digit = 4'(d);
        end
        if (code == PAD2_CODES[d]) begin
          evt.valid = 1'b1;
          evt.pad   = 1'b1;
          evt.digit = 4'(d);
        end
      end
    end
  end

endmodule

// File: rtl/studio2_keypad.sv
// Studio II keypad responder: PS/2 events -> per-key state, OUT 2 key-select
// latch, and registered active-low EF flags for the CDP1802.
import studio2_pkg::*;

module studio2_keypad #(
  parameter int         PRESCALE   = 1024,
  parameter int         HOLD_TICKS = 8,
  parameter logic [2:0] KEY_PORT   = DEFAULT_KEY_PORT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       ps2_key,
  studio2_keypad_if.slave   bus
);

  logic [15:0] pre_q;
  logic        tick;
  logic        old_toggle;
  logic        ps2_evt;
  key_evt_t    kev;

  logic [1:0][NUM_DIGITS-1:0]      down_q, down_d;
  logic [1:0][NUM_DIGITS-1:0][3:0] hold_q, hold_d;
  logic [3:0] key_sel_q, key_sel_d;
  logic [3:0] ef_q, ef_d;
  logic       sel1, sel2;
  logic       unused_dout_hi;

  assign unused_dout_hi = ^bus.io_dout[7:4];
  assign tick    = (pre_q == 16'(PRESCALE - 1));
  assign ps2_evt = ps2_key[10] ^ old_toggle;

  studio2_keymap u_keymap (
    .code     (ps2_key[7:0]),
    .extended (ps2_key[8]),
    .evt      (kev)
  );

  // Next state is computed first so EF reflects the post-update state.
  always_comb begin
    down_d    = down_q;
    hold_d    = hold_q;
    key_sel_d = key_sel_q;
    for (int p = 0; p < 2; p++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (tick && hold_q[p][d] != 4'd0) hold_d[p][d] = hold_q[p][d] - 4'd1;
      end
    end
    // A make overrides the tick decrement applied above.
    if (ps2_evt && kev.valid) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (kev.digit == 4'(d)) begin
          down_d[kev.pad][d] = ps2_key[9];
          if (ps2_key[9]) hold_d[kev.pad][d] = 4'(HOLD_TICKS);
        end
      end
    end
    if (bus.io_out && bus.io_n == KEY_PORT) key_sel_d = bus.io_dout[3:0];

    sel1 = 1'b0;
    sel2 = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (key_sel_d == 4'(d)) begin
        sel1 = down_d[0][d] | (hold_d[0][d] != 4'd0);
        sel2 = down_d[1][d] | (hold_d[1][d] != 4'd0);
      end
    end
    ef_d = {~sel2, ~sel1, 1'b1, ~bus.efx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      old_toggle <= ps2_key[10];
      down_q     <= '0;
      hold_q     <= '0;
      key_sel_q  <= '0;
      ef_q       <= 4'b1111;
    end else begin
      pre_q      <= tick ? 16'd0 : pre_q + 16'd1;
      old_toggle <= ps2_key[10];
      down_q     <= down_d;
      hold_q     <= hold_d;
      key_sel_q  <= key_sel_d;
      ef_q       <= ef_d;
    end
  end

  assign bus.ef      = ef_q;
  assign bus.key_sel = key_sel_q;

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad with PRESCALE=4, HOLD_TICKS=2.
// Single-cycle vectors from a table, then hand sequences for hold and reset.
module tb_studio2_keypad;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        tog = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          pre_m = 0;

  studio2_keypad_if bus ();

  studio2_keypad #(.PRESCALE(4), .HOLD_TICKS(2), .KEY_PORT(3'd2)) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic       pr;
    logic       ex;
    logic [7:0] code;
    logic       ov;
    logic [2:0] n;
    logic [7:0] d;
    logic       efx;
    logic [3:0] e_ef;
    logic [3:0] e_sel;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(input logic kv, input logic pr, input logic ex,
                              input logic [7:0] code, input logic ov,
                              input logic [2:0] n, input logic [7:0] d,
                              input logic efx, input logic [3:0] e_ef,
                              input logic [3:0] e_sel);
    vec_t v;
    v.kv = kv; v.pr = pr; v.ex = ex; v.code = code; v.ov = ov;
    v.n = n; v.d = d; v.efx = efx; v.e_ef = e_ef; v.e_sel = e_sel;
    return v;
  endfunction

  // One clock edge; pre_m tracks the DUT prescaler value before the next edge.
  task automatic step();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    pre_m = r ? 0 : (pre_m + 1) % 4;
    bus.io_out = 1'b0;
  endtask

  task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
    bus.io_out  = 1'b1;
    bus.io_n    = n;
    bus.io_dout = d;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int w;
    reset = 1'b1;
    ps2_key = '0;
    bus.io_out = 1'b0; bus.io_n = '0; bus.io_dout = '0; bus.efx = 1'b0;

    vt[0]  = mk(1, 1, 0, 8'h1E, 0, 3'd0, 8'h00, 0, 4'b1111, 4'h0);
    vt[1]  = mk(0, 0, 0, 8'h00, 1, 3'd2, 8'h02, 0, 4'b1011, 4'h2);
    vt[2]  = mk(0, 0, 0, 8'h00, 0, 3'd0, 8'h00, 1, 4'b1010, 4'h2);
    vt[3]  = mk(1, 1, 0, 8'h72, 0, 3'd0, 8'h00, 0, 4'b0011, 4'h2);
    vt[4]  = mk(0, 0, 0, 8'h00, 1, 3'd3, 8'h05, 0, 4'b0011, 4'h2);
    vt[5]  = mk(0, 0, 0, 8'h00, 1, 3'd2, 8'h0C, 0, 4'b1111, 4'hC);
    vt[6]  = mk(0, 0, 0, 8'h00, 1, 3'd2, 8'hF7, 0, 4'b1111, 4'h7);
    vt[7]  = mk(1, 1, 0, 8'h3D, 1, 3'd2, 8'h07, 0, 4'b1011, 4'h7);
    vt[8]  = mk(1, 1, 1, 8'h70, 1, 3'd2, 8'h00, 0, 4'b1111, 4'h0);
    vt[9]  = mk(1, 1, 0, 8'h1C, 0, 3'd0, 8'h00, 0, 4'b1111, 4'h0);
    vt[10] = mk(1, 1, 0, 8'h70, 0, 3'd0, 8'h00, 0, 4'b0111, 4'h0);
    vt[11] = mk(1, 1, 0, 8'h45, 0, 3'd0, 8'h00, 0, 4'b0011, 4'h0);
    vt[12] = mk(1, 0, 0, 8'h26, 1, 3'd2, 8'h03, 0, 4'b1111, 4'h3);

    step(); step(); step();
    check("reset_ef", bus.ef, 4'b1111);
    check("reset_sel", bus.key_sel, 4'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vt[i].kv) key(vt[i].pr, vt[i].ex, vt[i].code);
      if (vt[i].ov) cpu_out(vt[i].n, vt[i].d);
      bus.efx = vt[i].efx;
      step();
      check($sformatf("vec%0d_ef", i), bus.ef, vt[i].e_ef);
      check($sformatf("vec%0d_sel", i), bus.key_sel, vt[i].e_sel);
    end

    // Hold stretch: make lands on a tick edge, break right after, 8 clocks to release.
    cpu_out(3'd2, 8'h01); step();
    check("sel1_ef", bus.ef, 4'b1111);
    check("sel1_sel", bus.key_sel, 4'h1);
    w = 0;
    while (pre_m != 3 && w < 8) begin step(); w++; end
    key(1, 0, 8'h69); step();
    check("pad2_1_make", bus.ef, 4'b0111);
    key(0, 0, 8'h69); step();
    n = 1;
    check("pad2_1_held", bus.ef, 4'b0111);
    while (bus.ef[3] == 1'b0 && n < 20) begin step(); n++; end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL hold_release: got %0d clocks expected 8", n);
    end

    // Out-of-range selection hides a held pad1 key.
    key(1, 0, 8'h16); step();
    check("pad1_1_make", bus.ef, 4'b1011);
    cpu_out(3'd2, 8'h0C); step();
    check("sel_c_ef", bus.ef, 4'b1111);
    cpu_out(3'd2, 8'h0A); step();
    check("sel_a_ef", bus.ef, 4'b1111);
    check("sel_a_sel", bus.key_sel, 4'hA);
    cpu_out(3'd2, 8'h01); step();
    check("resel1_ef", bus.ef, 4'b1011);

    // Reset with 0x45 and 0x70 held and digit 0 latched; toggle moves during reset.
    cpu_out(3'd2, 8'h00); step();
    check("both0_ef", bus.ef, 4'b0011);
    reset = 1'b1;
    key(1, 0, 8'h70);
    step();
    check("midreset_ef", bus.ef, 4'b1111);
    check("midreset_sel", bus.key_sel, 4'h0);
    reset = 1'b0;
    step(); step();
    check("post_reset_ef", bus.ef, 4'b1111);
    key(0, 0, 8'h45); step();
    check("late_break_ef", bus.ef, 4'b1111);
    key(1, 0, 8'h45); step();
    check("remake_ef", bus.ef, 4'b1011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
